// File: rtl/core_inst_seq_pkg.sv
// Shared definitions for the conv-tile instruction sequencer: instruction bit map,
// idle instruction word and sequencer state encoding.
package core_inst_pkg;

  localparam int unsigned InstW = 35;
  localparam int unsigned AddrW = 11;

  localparam int unsigned BitRelu    = 34;
  localparam int unsigned BitAcc     = 33;
  localparam int unsigned BitCenP    = 32;
  localparam int unsigned BitWenP    = 31;
  localparam int unsigned BitAPLo    = 20;
  localparam int unsigned BitCenX    = 19;
  localparam int unsigned BitWenX    = 18;
  localparam int unsigned BitAXLo    = 7;
  localparam int unsigned BitOfifoRd = 6;
  localparam int unsigned BitIfifoWr = 5;
  localparam int unsigned BitIfifoRd = 4;
  localparam int unsigned BitL0Rd    = 3;
  localparam int unsigned BitL0Wr    = 2;
  localparam int unsigned BitExec    = 1;
  localparam int unsigned BitLoad    = 0;

  // Both memories disabled (CEN/WEN high), every control bit low.
  localparam logic [InstW-1:0] IdleInst = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    StIdle,
    StWL0,
    StWLoad,
    StWGap,
    StAL0,
    StExec,
    StDrain,
    StAcc
  } state_e;

endpackage

// File: rtl/core_inst_seq_acc.sv
// pmem read-address generator for the accumulate phase: walks the 3x3 window of
// each output pixel over the per-kij psum planes.
module acc_addr_gen
  import core_inst_pkg::*;
#(
  parameter int unsigned len_nij = 36,
  parameter int unsigned I_DIM   = 6,
  parameter int unsigned O_DIM   = 4,
  parameter int unsigned K_DIM   = 3,
  parameter int unsigned P_BASE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             next_k,
  input  logic             next_o,
  output logic [3:0]       onij,
  output logic [AddrW-1:0] addr
);

  localparam logic [3:0]       ODimC  = 4'(O_DIM);
  localparam logic [3:0]       KDimC  = 4'(K_DIM);
  localparam logic [AddrW-1:0] IDimA  = AddrW'(I_DIM);
  localparam logic [AddrW-1:0] NijA   = AddrW'(len_nij);
  localparam logic [AddrW-1:0] PBaseA = AddrW'(P_BASE);

  logic [3:0] onij_q;
  logic [3:0] kijp_q;
  logic [3:0] orow, ocol, ki, kj;

  always_ff @(posedge clk) begin
    if (reset || init) begin
      onij_q <= 4'd0;
      kijp_q <= 4'd0;
    end else if (next_o) begin
      onij_q <= onij_q + 4'd1;
      kijp_q <= 4'd0;
    end else if (next_k) begin
      kijp_q <= kijp_q + 4'd1;
    end
  end

  always_comb begin
    orow = onij_q / ODimC;
    ocol = onij_q % ODimC;
    ki   = kijp_q / KDimC;
    kj   = kijp_q % KDimC;
    addr = PBaseA + AddrW'(kijp_q) * NijA
         + (AddrW'(orow) + AddrW'(ki)) * IDimA
         + AddrW'(ocol) + AddrW'(kj);
  end

  assign onij = onij_q;

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer producing the full 3x3 conv schedule of one tile on the
// core's 35-bit inst bus, followed by the per-pixel accumulate + ReLU pass.
module core_inst_seq
  import core_inst_pkg::*;
#(
  parameter int unsigned col     = 8,
  parameter int unsigned row     = 8,
  parameter int unsigned len_nij = 36,
  parameter int unsigned I_DIM   = 6,
  parameter int unsigned O_DIM   = 4,
  parameter int unsigned K_DIM   = 3,
  parameter int unsigned W_BASE  = 1024,
  parameter int unsigned P_BASE  = 0,
  parameter int unsigned GAP     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ofifo_valid,
  output logic [InstW-1:0] inst,
  output logic             sfp_clr,
  output logic             busy,
  output logic             done,
  output logic             onij_valid,
  output logic [3:0]       onij_idx
);

  localparam int unsigned LenKij  = K_DIM * K_DIM;
  localparam int unsigned LenOnij = O_DIM * O_DIM;

  localparam logic [7:0] ColT     = 8'(col);
  localparam logic [7:0] RowT     = 8'(row);
  localparam logic [7:0] GapT     = 8'(GAP - 1);
  localparam logic [7:0] NijT     = 8'(len_nij);
  localparam logic [7:0] AccFetch = 8'(LenKij);
  localparam logic [7:0] AccLast  = 8'(LenKij + 1);
  localparam logic [7:0] AccRelu  = 8'(LenKij + 2);
  localparam logic [7:0] AccDone  = 8'(LenKij + 3);
  localparam logic [3:0] LastKij  = 4'(LenKij - 1);
  localparam logic [3:0] LastOnij = 4'(LenOnij - 1);

  localparam logic [AddrW-1:0] WBaseA = AddrW'(W_BASE);
  localparam logic [AddrW-1:0] ColA   = AddrW'(col);
  localparam logic [AddrW-1:0] NijA   = AddrW'(len_nij);
  localparam logic [AddrW-1:0] PBaseA = AddrW'(P_BASE);

  state_e           state;
  logic [7:0]       t;
  logic [3:0]       kij;
  logic [7:0]       rd_cnt;
  logic [7:0]       wr_cnt;
  logic             wr_pend;
  logic [InstW-1:0] inst_nxt;
  logic             rd_go;
  logic             acc_init, acc_next_k, acc_next_o;
  logic [3:0]       acc_onij;
  logic [AddrW-1:0] acc_addr;

  acc_addr_gen #(
    .len_nij(len_nij),
    .I_DIM  (I_DIM),
    .O_DIM  (O_DIM),
    .K_DIM  (K_DIM),
    .P_BASE (P_BASE)
  ) u_acc_addr_gen (
    .clk   (clk),
    .reset (reset),
    .init  (acc_init),
    .next_k(acc_next_k),
    .next_o(acc_next_o),
    .onij  (acc_onij),
    .addr  (acc_addr)
  );

  // Instruction for the current (state, t); registered into inst one cycle later.
  always_comb begin
    inst_nxt             = IdleInst;
    inst_nxt[BitIfifoWr] = 1'b0;
    inst_nxt[BitIfifoRd] = 1'b0;
    rd_go                = 1'b0;
    acc_init             = 1'b0;
    acc_next_k           = 1'b0;
    acc_next_o           = 1'b0;
    case (state)
      StWL0: begin
        if (t < ColT) begin
          inst_nxt[BitCenX]            = 1'b0;
          inst_nxt[BitAXLo +: AddrW]   = WBaseA + AddrW'(kij) * ColA + AddrW'(t);
        end
        inst_nxt[BitL0Wr] = (t != 8'd0);
      end
      StWLoad: begin
        inst_nxt[BitL0Rd] = 1'b1;
        inst_nxt[BitLoad] = (t != 8'd0);
      end
      StAL0: begin
        if (t < NijT) begin
          inst_nxt[BitCenX]          = 1'b0;
          inst_nxt[BitAXLo +: AddrW] = AddrW'(t);
        end
        inst_nxt[BitL0Wr] = (t != 8'd0);
      end
      StExec: begin
        inst_nxt[BitL0Rd] = 1'b1;
        inst_nxt[BitExec] = (t != 8'd0);
      end
      StDrain: begin
        if (wr_cnt != NijT) begin
          rd_go                = ofifo_valid && (rd_cnt < NijT);
          inst_nxt[BitOfifoRd] = rd_go;
          if (wr_pend) begin
            inst_nxt[BitCenP]          = 1'b0;
            inst_nxt[BitWenP]          = 1'b0;
            inst_nxt[BitAPLo +: AddrW] = PBaseA + AddrW'(kij) * NijA + AddrW'(wr_cnt);
          end
        end else begin
          acc_init = (kij == LastKij);
        end
      end
      StAcc: begin
        if (t >= 8'd1 && t <= AccFetch) begin
          inst_nxt[BitCenP]          = 1'b0;
          inst_nxt[BitAPLo +: AddrW] = acc_addr;
          acc_next_k                 = 1'b1;
        end
        // pmem data arrives one cycle after its address.
        inst_nxt[BitAcc]  = (t >= 8'd2 && t <= AccLast);
        inst_nxt[BitRelu] = (t == AccRelu);
        acc_next_o        = (t == AccRelu) && (acc_onij != LastOnij);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      inst       <= IdleInst;
      sfp_clr    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      onij_valid <= 1'b0;
      onij_idx   <= 4'd0;
      t          <= 8'd0;
      kij        <= 4'd0;
      rd_cnt     <= 8'd0;
      wr_cnt     <= 8'd0;
      wr_pend    <= 1'b0;
    end else begin
      inst       <= inst_nxt;
      sfp_clr    <= 1'b0;
      done       <= 1'b0;
      onij_valid <= 1'b0;
      t          <= t + 8'd1;
      case (state)
        StIdle: begin
          t <= 8'd0;
          if (start) begin
            state <= StWL0;
            busy  <= 1'b1;
            kij   <= 4'd0;
          end
        end
        StWL0: if (t == ColT) begin
          state <= StWLoad;
          t     <= 8'd0;
        end
        StWLoad: if (t == RowT) begin
          state <= StWGap;
          t     <= 8'd0;
        end
        StWGap: if (t == GapT) begin
          state <= StAL0;
          t     <= 8'd0;
        end
        StAL0: if (t == NijT) begin
          state <= StExec;
          t     <= 8'd0;
        end
        StExec: if (t == NijT) begin
          state   <= StDrain;
          t       <= 8'd0;
          rd_cnt  <= 8'd0;
          wr_cnt  <= 8'd0;
          wr_pend <= 1'b0;
        end
        StDrain: begin
          t <= 8'd0;
          if (wr_cnt == NijT) begin
            if (kij == LastKij) begin
              state <= StAcc;
            end else begin
              state <= StWL0;
              kij   <= kij + 4'd1;
            end
          end else begin
            wr_pend <= rd_go;
            if (rd_go) rd_cnt <= rd_cnt + 8'd1;
            if (wr_pend) wr_cnt <= wr_cnt + 8'd1;
          end
        end
        StAcc: begin
          sfp_clr <= (t == 8'd0);
          if (t == AccRelu) begin
            onij_valid <= 1'b1;
            onij_idx   <= acc_onij;
            if (acc_onij != LastOnij) t <= 8'd0;
          end
          if (t == AccDone) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StIdle;
            t     <= 8'd0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: expected memory addresses and pixel indices are
// queued from the schedule formulas at start, then popped as the inst bus issues them.
module tb_core_inst_seq;

  localparam logic [34:0] IDLE = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [34:0] inst;
  logic        sfp_clr, busy, done, onij_valid;
  logic [3:0]  onij_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_single = 0;

  logic        xrd, prd, pwr;
  logic [10:0] ax, ap;
  assign xrd = ~inst[19];
  assign ax  = inst[17:7];
  assign prd = ~inst[32] & inst[31];
  assign pwr = ~inst[32] & ~inst[31];
  assign ap  = inst[30:20];

  core_inst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .sfp_clr    (sfp_clr),
    .busy       (busy),
    .done       (done),
    .onij_valid (onij_valid),
    .onij_idx   (onij_idx)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (inst !== IDLE) begin
      n_bad++;
      $display("FAIL reset_inst: got %h want %h", inst, IDLE);
    end
    n_cmp++;
    if ({busy, done, sfp_clr, onij_valid} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, sfp_clr, onij_valid});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (inst !== IDLE || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: got inst %h busy %b want %h 0", inst, busy, IDLE);
    end
  endtask

  task automatic test_mid_reset();
    bit seen4 = 0;
    bit hit = 0;
    int cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!hit && cyc < 5000) begin
      if (xrd && ax == 11'd1056) seen4 = 1;
      if (seen4 && inst[1]) hit = 1;
      else begin
        ofifo_valid = (cyc % 2) == 1;
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL mid_reset_reach: got no kij4 execute want execute within 5000 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (inst !== IDLE || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_abort: got inst %h busy %b want %h 0", inst, busy, IDLE);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (inst !== IDLE || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_noresume: got inst %h busy %b want %h 0", inst, busy, IDLE);
    end
  endtask

  task automatic test_full_tile(input bit extra, output int cycles);
    int xq[$];
    int wq[$];
    int rq[$];
    int oq[$];
    int e;
    bit fin = 0;
    bit p_xrd = 0, p_prd = 0, p_ofrd = 0, p_ofv = 0;
    int n_load = 0, n_exec = 0, n_clr = 0, n_ofrd = 0;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 8; c++) xq.push_back(1024 + k * 8 + c);
      for (int p = 0; p < 36; p++) xq.push_back(p);
      for (int p = 0; p < 36; p++) wq.push_back(k * 36 + p);
    end
    for (int o = 0; o < 16; o++) begin
      for (int kk = 0; kk < 9; kk++)
        rq.push_back(kk * 36 + (o / 4 + kk / 3) * 6 + (o % 4) + (kk % 3));
      oq.push_back(o);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    cycles = 0;
    while (!fin && cycles < 20000) begin
      if (xrd) begin
        n_cmp++;
        if (xq.size() == 0) begin
          n_bad++;
          $display("FAIL xmem_extra: got read at %0d want none", ax);
        end else begin
          e = xq.pop_front();
          if (ax !== 11'(e) || inst[18] !== 1'b1) begin
            n_bad++;
            $display("FAIL xmem_addr: got %0d wen %b want %0d wen 1", ax, inst[18], e);
          end
        end
      end
      n_cmp++;
      if (inst[2] !== p_xrd) begin
        n_bad++;
        $display("FAIL l0_wr_lag: got %b want %b at cycle %0d", inst[2], p_xrd, cycles);
      end
      if (pwr) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL pmem_wr_extra: got write at %0d want none", ap);
        end else begin
          e = wq.pop_front();
          if (ap !== 11'(e)) begin
            n_bad++;
            $display("FAIL pmem_wr_addr: got %0d want %0d", ap, e);
          end
        end
      end
      n_cmp++;
      if (pwr !== p_ofrd) begin
        n_bad++;
        $display("FAIL wr_after_rd: got %b want %b at cycle %0d", pwr, p_ofrd, cycles);
      end
      if (inst[6] && !p_ofv) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ofifo_rd_no_valid: got rd 1 want 0 at cycle %0d", cycles);
      end
      if (prd) begin
        n_cmp++;
        if (rq.size() == 0) begin
          n_bad++;
          $display("FAIL pmem_rd_extra: got read at %0d want none", ap);
        end else begin
          e = rq.pop_front();
          if (ap !== 11'(e)) begin
            n_bad++;
            $display("FAIL pmem_rd_addr: got %0d want %0d", ap, e);
          end
        end
      end
      n_cmp++;
      if (inst[33] !== p_prd) begin
        n_bad++;
        $display("FAIL acc_lag: got %b want %b at cycle %0d", inst[33], p_prd, cycles);
      end
      n_cmp++;
      if (inst[34] !== onij_valid || inst[5:4] !== 2'b00 || (inst[34] && inst[33])) begin
        n_bad++;
        $display("FAIL relu_ififo: got relu %b valid %b acc %b ififo %b want relu==valid, no acc, 00",
                 inst[34], onij_valid, inst[33], inst[5:4]);
      end
      if (onij_valid) begin
        n_cmp++;
        if (oq.size() == 0) begin
          n_bad++;
          $display("FAIL onij_extra: got idx %0d want none", onij_idx);
        end else begin
          e = oq.pop_front();
          if (onij_idx !== 4'(e)) begin
            n_bad++;
            $display("FAIL onij_idx: got %0d want %0d", onij_idx, e);
          end
        end
      end
      n_load += int'(inst[0]);
      n_exec += int'(inst[1]);
      n_clr  += int'(sfp_clr);
      n_ofrd += int'(inst[6]);
      if (done) begin
        fin = 1;
        n_cmp++;
        if (xq.size() + wq.size() + rq.size() + oq.size() != 0) begin
          n_bad++;
          $display("FAIL queues_left: got x%0d w%0d r%0d o%0d want all 0",
                   xq.size(), wq.size(), rq.size(), oq.size());
        end
        n_cmp++;
        if (n_load != 72 || n_exec != 324 || n_clr != 16 || n_ofrd != 324) begin
          n_bad++;
          $display("FAIL pulse_counts: got load %0d exec %0d clr %0d ofrd %0d want 72 324 16 324",
                   n_load, n_exec, n_clr, n_ofrd);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_at_done: got %b want 0", busy);
        end
      end else begin
        p_xrd  = xrd;
        p_prd  = prd;
        p_ofrd = inst[6];
        ofifo_valid = (cycles % 2) == 1;
        p_ofv  = ofifo_valid;
        start  = extra && (cycles == 100 || cycles == 900);
        @(negedge clk);
        cycles++;
      end
    end
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL tile_timeout: got no done want done within 20000 cycles");
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || inst !== IDLE) begin
      n_bad++;
      $display("FAIL post_done: got done %b busy %b inst %h want 0 0 %h", done, busy, inst, IDLE);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    test_full_tile(1'b1, cyc);
    n_cmp++;
    if (cyc != cyc_single) begin
      n_bad++;
      $display("FAIL busy_start_cycles: got %0d want %0d", cyc, cyc_single);
    end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_full_tile(1'b0, cyc_single);
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
